fifo_serial_tx: RTL and testbench

Read-side consumer for the LFSR-addressed synchronous FIFO. It pops one word whenever the FIFO is non-empty and transmission is enabled, then sends the word on a single-wire asynchronous serial line. Each frame has a start bit, DATA_WIDTH data bits sent LSB first, an optional parity bit and 1 or 2 stop bits. It connects directly to the FIFO's `FIFO_empty`, `rd_en` and `data_out` (registered, one-cycle read latency) and shares the FIFO clock and reset.

---
 rtl/fifo_serial_pkg.sv | 20 ++
 rtl/fifo_serial_tx_if.sv | 21 ++
 rtl/serial_bit_timer.sv | 33 +++
 rtl/fifo_serial_tx.sv | 139 +++++++++++++
 tb/tb_fifo_serial_tx.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_serial_pkg.sv
// Shared types for the FIFO-fed serial transmitter: FSM state encoding and frame-length helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package fifo_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Serial bits per frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_width, input int parity_en, input int stop_bits);
        return 1 + data_width + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO read port seen by the serial transmitter: empty flag, registered read data, pop strobe.
// Data is valid the cycle after fifo_rd_en; the consumer only pops when empty was sampled low.
interface fifo_serial_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: bit_tick pulses on the last clk of every CLKS_PER_BIT-cycle bit period.
// Zero latency decode of the counter; clear holds it at 0 so the first period starts aligned.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fifo_serial_tx.sv
// Pops one word from the FIFO and sends it as start/data(LSB first)/parity/stop on tx.
// Pop-to-start-bit is 2 cycles; no new pop while a frame is in flight or enable is low.
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    fifo_serial_tx_if.master  fifo,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);
    localparam int               IDX_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic             PAR_ODD  = (PARITY_ODD != 0);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  parity_q, parity_d;
    logic                  stop_q, stop_d;
    logic                  tx_q, tx_d;
    logic                  bit_tick;
    logic                  timer_clear;
    logic                  start_ok;

    // Timer is held at 0 outside the serial states so START always gets a full period.
    assign timer_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    assign start_ok        = enable && !fifo.fifo_empty;
    assign fifo.fifo_rd_en = (state_q == FETCH);
    assign busy            = (state_q != IDLE);
    assign tx              = tx_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        parity_d   = parity_q;
        stop_d     = stop_q;
        frame_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d  = fifo.fifo_data;
                parity_d = (^fifo.fifo_data) ^ PAR_ODD;
                state_d  = START;
            end
            START: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        stop_d    = 1'b0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if ((STOP_BITS == 2) && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        stop_d     = 1'b0;
                        frame_done = 1'b1;
                        state_d    = start_ok ? FETCH : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes together with state_q.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            stop_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
        end
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: three parameter sets each fed by a behavioural registered-output FIFO,
// frames compared cycle by cycle against waveforms computed from the frame format.
module tb_fifo_serial_tx;
    localparam int         CPB   = 4;
    localparam logic [2:0] P_EN  = 3'b110;
    localparam logic [2:0] P_ODD = 3'b100;
    localparam logic [2:0] STOP2 = 3'b010;

    logic       clk;
    logic       rst;
    logic [2:0] enable;
    logic [2:0] tx_w, busy_w, fd_w, rd_w, emp_w;
    logic [2:0] push_vld;
    logic [7:0] push_dat [3];

    int checks = 0;
    int errors = 0;
    int exp_pops [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar gd = 0; gd < 3; gd++) begin : u
        fifo_serial_tx_if #(.DATA_WIDTH(8)) fif ();

        fifo_serial_tx #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (P_EN[gd] ? 1 : 0),
            .PARITY_ODD  (P_ODD[gd] ? 1 : 0),
            .STOP_BITS   (STOP2[gd] ? 2 : 1)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable[gd]),
            .fifo      (fif),
            .tx        (tx_w[gd]),
            .busy      (busy_w[gd]),
            .frame_done(fd_w[gd])
        );

        logic [7:0] mem [16];
        logic [4:0] wp, rp;
        logic [7:0] dq;
        int pops = 0;
        int bad  = 0;

        assign fif.fifo_empty = (wp == rp);
        assign fif.fifo_data  = dq;
        assign rd_w[gd]       = fif.fifo_rd_en;
        assign emp_w[gd]      = fif.fifo_empty;

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                wp <= '0;
                rp <= '0;
                dq <= '0;
            end else begin
                if (push_vld[gd]) begin
                    mem[wp[3:0]] <= push_dat[gd];
                    wp <= wp + 1'b1;
                end
                if (fif.fifo_rd_en && (wp != rp)) begin
                    dq <= mem[rp[3:0]];
                    rp <= rp + 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            if (rst && rd_w[gd]) begin
                pops <= pops + 1;
                if (emp_w[gd]) bad <= bad + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int g, input logic [7:0] w);
        push_vld[g] = 1'b1;
        push_dat[g] = w;
        @(negedge clk);
        push_vld[g] = 1'b0;
    endtask

    function automatic int frame_cycles(input int g);
        return (1 + 8 + (P_EN[g] ? 1 : 0) + (STOP2[g] ? 2 : 1)) * CPB;
    endfunction

    // Expected tx at a cycle offset from the pop cycle (offset 0 = pop, 1 = load gap).
    function automatic logic exp_tx_at(input int g, input logic [7:0] w, input int off);
        int k;
        if (off < 2) return 1'b1;
        k = (off - 2) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return w[k-1];
        if (k == 9 && P_EN[g]) return (^w) ^ P_ODD[g];
        return 1'b1;
    endfunction

    task automatic run_frame(input int g, input logic [7:0] w, input int drop_off,
                             output int waited, output int flen, output logic pbit);
        logic [63:0] a_tx, e_tx, a_fd, e_fd, a_bz, e_bz, a_rd, e_rd;
        int nc, fz, fo;
        logic got;
        nc = frame_cycles(g);
        got = 1'b0;
        waited = 0;
        flen = 0;
        pbit = 1'b0;
        while (!got && waited < 300) begin
            @(negedge clk);
            waited++;
            got = rd_w[g];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL pop_timeout g%0d w%02h: no fifo_rd_en in %0d cycles, required one", g, w, waited);
            return;
        end
        a_tx = '0; e_tx = '0; a_fd = '0; e_fd = '0;
        a_bz = '0; e_bz = '0; a_rd = '0; e_rd = 64'd1;
        for (int off = 0; off <= nc + 1; off++) begin
            if (off > 0) @(negedge clk);
            a_tx[off] = tx_w[g];
            a_fd[off] = fd_w[g];
            a_bz[off] = busy_w[g];
            a_rd[off] = rd_w[g];
            e_tx[off] = exp_tx_at(g, w, off);
            e_fd[off] = (off == nc + 1);
            e_bz[off] = 1'b1;
            if (off == drop_off) enable[g] = 1'b0;
        end
        chk($sformatf("tx_wave g%0d w%02h", g, w), a_tx, e_tx);
        chk($sformatf("frame_done g%0d w%02h", g, w), a_fd, e_fd);
        chk($sformatf("busy g%0d w%02h", g, w), a_bz, e_bz);
        chk($sformatf("rd_en g%0d w%02h", g, w), a_rd, e_rd);
        fz = -1;
        fo = -1;
        for (int off = 0; off <= nc + 1; off++) begin
            if (!a_tx[off] && fz < 0) fz = off;
            if (a_fd[off] && fo < 0) fo = off;
        end
        if (fz >= 0 && fo >= 0) flen = fo - fz + 1;
        pbit = a_tx[2 + 9 * CPB];
    endtask

    typedef struct {
        int         g;
        logic [7:0] w;
        logic       chk_par;
        logic       par;
        int         flen;
    } vec_t;

    initial begin
        vec_t tbl [7];
        int waited, flen, act, k;
        logic pbit;
        logic [7:0] ws [4];

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b0, 40};
        tbl[1] = '{1, 8'hA5, 1'b1, 1'b0, 48};
        tbl[2] = '{2, 8'hA5, 1'b1, 1'b1, 44};
        tbl[3] = '{1, 8'h07, 1'b1, 1'b1, 48};
        tbl[4] = '{2, 8'h00, 1'b1, 1'b1, 44};
        tbl[5] = '{2, 8'hFF, 1'b1, 1'b1, 44};
        tbl[6] = '{0, 8'h3C, 1'b0, 1'b0, 40};

        rst = 1'b0;
        enable = '0;
        push_vld = '0;
        for (int g = 0; g < 3; g++) begin
            push_dat[g] = '0;
            exp_pops[g] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset_tx g%0d", g), 64'(tx_w[g]), 64'd1);
            chk($sformatf("reset_busy g%0d", g), 64'(busy_w[g]), 64'd0);
            chk($sformatf("reset_rd_en g%0d", g), 64'(rd_w[g]), 64'd0);
            chk($sformatf("reset_frame_done g%0d", g), 64'(fd_w[g]), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Empty FIFO with enable high: nothing may happen.
        enable = 3'b111;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if ((rd_w | busy_w | fd_w | ~tx_w) != 3'b000) act++;
        end
        chk("empty_idle_activity", 64'(act), 64'd0);
        enable = '0;

        // Single frames per configuration.
        for (int i = 0; i < 7; i++) begin
            push(tbl[i].g, tbl[i].w);
            exp_pops[tbl[i].g]++;
            enable[tbl[i].g] = 1'b1;
            run_frame(tbl[i].g, tbl[i].w, -1, waited, flen, pbit);
            enable[tbl[i].g] = 1'b0;
            chk($sformatf("pop_latency t%0d", i), 64'(waited), 64'd1);
            chk($sformatf("frame_len t%0d", i), 64'(flen), 64'(tbl[i].flen));
            if (tbl[i].chk_par) chk($sformatf("parity t%0d", i), 64'(pbit), 64'(tbl[i].par));
            @(negedge clk);
            chk($sformatf("busy_after t%0d", i), 64'(busy_w[tbl[i].g]), 64'd0);
        end

        // Three queued words, enable held: back-to-back frames with a 2-cycle gap.
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        exp_pops[0] += 3;
        enable[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            run_frame(0, 8'(i), -1, waited, flen, pbit);
            chk($sformatf("b2b_gap %0d", i), 64'(waited), 64'd1);
        end
        @(negedge clk);
        enable[0] = 1'b0;
        chk("b2b_busy_after", 64'(busy_w[0]), 64'd0);

        // Enable dropped during the data bits of the first of two words.
        push(0, 8'h11);
        push(0, 8'h22);
        exp_pops[0] += 2;
        enable[0] = 1'b1;
        run_frame(0, 8'h11, 10, waited, flen, pbit);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_w[0] || busy_w[0]) act++;
        end
        chk("drop_enable_no_pop", 64'(act), 64'd0);
        chk("drop_enable_not_empty", 64'(emp_w[0]), 64'd0);
        enable[0] = 1'b1;
        run_frame(0, 8'h22, -1, waited, flen, pbit);
        chk("reenable_latency", 64'(waited), 64'd1);
        enable[0] = 1'b0;
        @(negedge clk);

        // Random bursts across all configurations.
        for (int it = 0; it < 9; it++) begin
            int g;
            g = it % 3;
            k = $urandom_range(1, 4);
            for (int i = 0; i < k; i++) begin
                ws[i] = 8'($urandom);
                push(g, ws[i]);
            end
            exp_pops[g] += k;
            enable[g] = 1'b1;
            for (int i = 0; i < k; i++) begin
                run_frame(g, ws[i], -1, waited, flen, pbit);
                chk($sformatf("rand_gap it%0d f%0d", it, i), 64'(waited), 64'd1);
            end
            enable[g] = 1'b0;
            @(negedge clk);
            chk($sformatf("rand_busy_after it%0d", it), 64'(busy_w[g]), 64'd0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Reset asserted during data bit 3 of 0xA5 (tx low there).
        push(0, 8'hA5);
        exp_pops[0]++;
        enable[0] = 1'b1;
        k = 0;
        while (!rd_w[0] && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (19) @(negedge clk);
        chk("pre_reset_tx_bit3", 64'(tx_w[0]), 64'd0);
        #1 rst = 1'b0;
        #1;
        chk("async_reset_tx", 64'(tx_w[0]), 64'd1);
        chk("async_reset_busy", 64'(busy_w[0]), 64'd0);
        chk("async_reset_rd_en", 64'(rd_w[0]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        act = 0;
        repeat (50) begin
            @(negedge clk);
            if (rd_w[0] || busy_w[0] || fd_w[0] || !tx_w[0]) act++;
        end
        chk("post_reset_quiet", 64'(act), 64'd0);
        enable[0] = 1'b0;

        chk("pop_count g0", 64'(u[0].pops), 64'(exp_pops[0]));
        chk("pop_count g1", 64'(u[1].pops), 64'(exp_pops[1]));
        chk("pop_count g2", 64'(u[2].pops), 64'(exp_pops[2]));
        chk("pop_while_empty g0", 64'(u[0].bad), 64'd0);
        chk("pop_while_empty g1", 64'(u[1].bad), 64'd0);
        chk("pop_while_empty g2", 64'(u[2].bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
